// File: rtl/div_stream_pkg.sv
// Shared types and helpers for the serial divisibility front end.
package div_stream_pkg;

  // Feeder FSM states; idle is the all-zeros encoding.
  typedef enum logic [1:0] {
    StIdle   = 2'b00,
    StClear  = 2'b01,
    StShift  = 2'b10,
    StSample = 2'b11
  } feeder_state_t;

  // Clamp a requested bit count to the physical number width.
  function automatic int unsigned clamp_len(input int unsigned len, input int unsigned max_len);
    return (len > max_len) ? max_len : len;
  endfunction

endpackage

// File: rtl/serial_divisibility_feeder_if.sv
// Handshake, serial-stream and result signals between the feeder and its environment.
interface serial_divisibility_feeder_if #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned LEN_W = $clog2(WIDTH + 1)
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic [LEN_W-1:0] in_len;
  logic             out_clear;
  logic             out_bit;
  logic             out_valid;
  logic             div_in;
  logic             res_valid;
  logic             res_div;

  // Environment side: offers numbers and returns the checker flag.
  modport master (
    output in_valid, in_data, in_len, div_in,
    input  in_ready, out_clear, out_bit, out_valid, res_valid, res_div
  );

  // Feeder side.
  modport slave (
    input  in_valid, in_data, in_len, div_in,
    output in_ready, out_clear, out_bit, out_valid, res_valid, res_div
  );
endinterface

// File: rtl/serial_divisibility_feeder.sv
// Parallel-to-serial framer for the serial divisibility checker FSMs: clears the
// checker, streams a number MSB-first and returns the sampled divisibility flag.
module serial_divisibility_feeder
  import div_stream_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned LEN_W = $clog2(WIDTH + 1)
) (
  input logic                          clk,
  input logic                          rst,
  serial_divisibility_feeder_if.slave  bus
);

  feeder_state_t    state_q, state_d;
  logic [LEN_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] sh_q, sh_d;
  logic             res_valid_q;
  logic             res_div_q;
  int unsigned      len_c;

  // Next-state logic; the number is left-aligned at capture so the MSB of the
  // significant field always sits at sh_q[WIDTH-1].
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sh_d    = sh_q;
    len_c   = clamp_len(32'(bus.in_len), WIDTH);
    unique case (state_q)
      StIdle: begin
        if (bus.in_valid) begin
          cnt_d   = LEN_W'(len_c);
          sh_d    = bus.in_data << (WIDTH - len_c);
          state_d = StClear;
        end
      end
      StClear: begin
        state_d = (cnt_q == '0) ? StSample : StShift;
      end
      StShift: begin
        sh_d  = sh_q << 1;
        cnt_d = cnt_q - LEN_W'(1);
        if (cnt_q == LEN_W'(1)) begin
          state_d = StSample;
        end
      end
      StSample: begin
        state_d = StIdle;
      end
    endcase
  end

  // State, counter, shift register and registered result; rst abandons any number.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      sh_q        <= '0;
      res_valid_q <= 1'b0;
      res_div_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      sh_q        <= sh_d;
      res_valid_q <= (state_q == StSample);
      res_div_q   <= (state_q == StSample) & bus.div_in;
    end
  end

  assign bus.in_ready  = (state_q == StIdle);
  assign bus.out_clear = (state_q == StClear);
  assign bus.out_valid = (state_q == StShift);
  assign bus.out_bit   = (state_q == StShift) & sh_q[WIDTH-1];
  assign bus.res_valid = res_valid_q;
  assign bus.res_div   = res_div_q;

endmodule

// File: doc/serial_divisibility_feeder.md
# serial_divisibility_feeder

Parallel-to-serial front end for the serial divisibility checkers (`div_by_3` / `div_by_5` FSMs). It accepts one number per valid/ready handshake and clears the checker. It then streams the number MSB-first, one bit per cycle, and samples the checker's divisibility flag after the last bit. The flag is returned as a one-cycle registered result. The block owns framing, so the free-running checker FSM never sees idle-cycle zeros as part of a number.

## Interface
Parameters:
- `WIDTH`, default 8: maximum number width in bits.
- `LEN_W`, default `$clog2(WIDTH+1)`: width of the length field.

Ports:
- `clk`  in  1  clock.
- `rst`  in  1  reset; synchronous, active-high.
- `in_valid`  in  1  number offered.
- `in_ready`  out  1  block can accept a number.
- `in_data`  in  WIDTH  number; significant bits are `[in_len-1:0]`.
- `in_len`  in  LEN_W  count of significant bits; range 0..WIDTH; larger values are clamped to WIDTH.
- `out_clear`  out  1  checker clear pulse; integration wires checker reset as `rst | out_clear`.
- `out_bit`  out  1  serial bit to the checker's `new_bit`.
- `out_valid`  out  1  `out_bit` is part of the current number.
- `div_in`  in  1  checker's `div_by_N` output.
- `res_valid`  out  1  one-cycle result pulse.
- `res_div`  out  1  1 if the number is divisible; valid only with `res_valid`.

## Operation
- FSM states: IDLE, CLEAR, SHIFT, SAMPLE.
  - IDLE: `in_ready`=1. On `in_valid`, capture `in_data` into the shift register and `min(in_len, WIDTH)` into the bit counter, then go to CLEAR.
  - CLEAR: `out_clear`=1 for exactly one cycle. If the captured length is 0, go to SAMPLE; otherwise go to SHIFT.
  - SHIFT: `out_valid`=1. `out_bit` = the captured bit `[cnt-1]`. Decrement `cnt` each cycle. On the cycle with `cnt`==1, go to SAMPLE.
  - SAMPLE: register `res_div <= div_in` and `res_valid <= 1`, then go to IDLE.
- Outside SHIFT, `out_bit` and `out_valid` are 0. The checker consumes those zeros, which is harmless because the result was already sampled and the next number starts with CLEAR.
- `in_ready` is 1 only in IDLE. A held `in_valid` during CLEAR, SHIFT or SAMPLE is not accepted; the upstream keeps the data stable.
- Length 0 yields the cleared checker's flag. That flag is 1, since 0 is divisible.
- Reset values: state IDLE. `in_ready`=1 in the first cycle after reset; all other outputs 0; counter and shift register 0.
- Reset mid-number: the number is abandoned and no `res_valid` is emitted for it. The checker is cleared by the shared `rst`.

## Timing
- Accept at cycle T (IDLE, `in_valid`&`in_ready`).
- T+1: `out_clear`=1.
- T+2 .. T+1+L: bits MSB-first, where L is the clamped length.
- T+2+L: SAMPLE; `div_in` reflects all L bits.
- T+3+L: `res_valid`=1 with `res_div` (registered).
- The FSM is back in IDLE at T+3+L, so the next accept can coincide with `res_valid`.
- Throughput: one number per L+3 cycles.
- L=0: CLEAR at T+1, SAMPLE at T+2, `res_valid` at T+3.
- Checker interaction: the checker's state updates at the edge ending each SHIFT cycle. Its reset by `out_clear` takes effect at the edge ending CLEAR.

## Structure
- Package `div_stream_pkg`:
  - `feeder_state_t` enum (IDLE, CLEAR, SHIFT, SAMPLE), 2-bit, IDLE = 2'b00.
  - Length clamp function.
- Sub-modules: none inside the feeder; one `always_ff` block for state/counter/shift register and one `always_comb` block for next-state logic.
- Top-level pairing: testbench or wrapper `serial_divisibility_system` instantiating the feeder plus `serial_divisibility_by_5_using_fsm`.

## Test plan
- `in_data`=8'd10, `in_len`=4, with the by-5 checker → `out_bit` sequence 1,0,1,0 at T+2..T+5; `res_valid` at T+7 with `res_div`=1. Same number with the by-3 checker → `res_div`=0.
- `in_data`=8'd255, `in_len`=8, with by-3 → 8 ones; `res_div`=1 at T+11. Then `in_data`=8'd7, `in_len`=3, offered back-to-back at T+11 → accepted at T+11, `out_clear` at T+12, `res_div`=0 at T+17.
- `in_len`=0 → no `out_valid`; `res_valid`=1 with `res_div`=1 at T+3.
- `in_len`=12 with WIDTH=8 and `in_data`=8'hFF → clamped to 8 bits; result at T+11.
- `in_valid` held high during a busy number → `in_ready`=0 with no capture until IDLE; the second number is accepted exactly at the cycle `res_valid` pulses for the first.
- `rst` asserted in the middle of SHIFT (third bit) → next cycle: IDLE, `in_ready`=1, `out_valid`=0, and no `res_valid` ever emitted for the abandoned number.
